// File: rtl/board_ram_arbiter_if.sv
// Requester-side bus of the board RAM write arbiter: one flattened slice per
// requester for req/lock/address/data, plus the one-hot grant coming back.
interface board_ram_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [5*NUM_REQ-1:0]  addr_i;
  logic [10*NUM_REQ-1:0] data_i;
  logic [NUM_REQ-1:0]    gnt;

  // Requesters drive the request side and observe the grant.
  modport master (
    output req,
    output lock,
    output addr_i,
    output data_i,
    input  gnt
  );

  // The arbiter observes requests and drives the grant.
  modport slave (
    input  req,
    input  lock,
    input  addr_i,
    input  data_i,
    output gnt
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: round-robin owner of the single board RAM write port.
// Requesters handshake with req/gnt; a requester holding lock keeps the port
// across back-to-back writes. Optional feature macro BOARD_CLEAR_EN adds a
// clear sweep (after reset and on clear_i) that writes zero to all 32 cells.
module board_ram_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                clk,
  input  logic                rst,
  board_ram_arbiter_if.slave  bus,
  input  logic                clear_i,
  output logic                we_ram_board,
  output logic [4:0]          addr_ram_board,
  output logic [9:0]          bus_data_o_ram_board,
  output logic                busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

`ifdef BOARD_CLEAR_EN
  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCKED = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCKED = 2'd1
  } state_t;
  localparam state_t RESET_STATE = ST_ARB;
`endif

  state_t                state_r;
  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      owner_r;
  logic                  we_r;
  logic [4:0]            addr_r;
  logic [9:0]            data_r;
`ifdef BOARD_CLEAR_EN
  logic [4:0]            cnt_r;
`endif

  logic                  rr_found_s;
  logic [PTR_W-1:0]      rr_win_s;
  logic [PTR_W-1:0]      cand_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [PTR_W-1:0]      win_s;
  logic                  hs_s;
  logic [4:0]            win_addr_s;
  logic [9:0]            win_data_s;

  // Next requester index in round-robin order, wrapping after the last one.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return {PTR_W{1'b0}};
    end else begin
      return idx + PTR_W'(1);
    end
  endfunction

  // Find the first requesting index at or after the round-robin pointer.
  always_comb begin
    rr_found_s = 1'b0;
    rr_win_s   = ptr_r;
    cand_s     = ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found_s && bus.req[cand_s]) begin
        rr_found_s = 1'b1;
        rr_win_s   = cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
      cand_s = wrap_inc(cand_s);
    end
  end

  // Grant decode: round-robin winner in ARB, owner only in LOCKED, none otherwise.
  always_comb begin
    gnt_s = {NUM_REQ{1'b0}};
    win_s = rr_win_s;
    if (rst) begin
      gnt_s = {NUM_REQ{1'b0}};
    end else begin
      case (state_r)
        ST_ARB: begin
`ifdef BOARD_CLEAR_EN
          if (clear_i) begin
            gnt_s = {NUM_REQ{1'b0}};
          end else if (rr_found_s) begin
            gnt_s[rr_win_s] = 1'b1;
          end else begin
            gnt_s = {NUM_REQ{1'b0}};
          end
`else
          if (rr_found_s) begin
            gnt_s[rr_win_s] = 1'b1;
          end else begin
            gnt_s = {NUM_REQ{1'b0}};
          end
`endif
        end
        ST_LOCKED: begin
          win_s          = owner_r;
          gnt_s[owner_r] = bus.req[owner_r];
        end
        default: begin
          gnt_s = {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  assign hs_s       = |(bus.req & gnt_s);
  assign win_addr_s = bus.addr_i[5*int'(win_s) +: 5];
  assign win_data_s = bus.data_i[10*int'(win_s) +: 10];
  assign bus.gnt    = gnt_s;

  // Arbiter state machine and registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RESET_STATE;
      ptr_r   <= {PTR_W{1'b0}};
      owner_r <= {PTR_W{1'b0}};
      we_r    <= 1'b0;
      addr_r  <= 5'd0;
      data_r  <= 10'd0;
`ifdef BOARD_CLEAR_EN
      cnt_r   <= 5'd0;
`endif
    end else begin
      we_r <= 1'b0;
      case (state_r)
`ifdef BOARD_CLEAR_EN
        ST_CLEAR: begin
          we_r   <= 1'b1;
          addr_r <= cnt_r;
          data_r <= 10'd0;
          cnt_r  <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_ARB;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
`endif
        ST_ARB: begin
`ifdef BOARD_CLEAR_EN
          if (clear_i) begin
            state_r <= ST_CLEAR;
            cnt_r   <= 5'd0;
          end else if (hs_s) begin
            we_r   <= 1'b1;
            addr_r <= win_addr_s;
            data_r <= win_data_s;
            ptr_r  <= wrap_inc(win_s);
            if (bus.lock[win_s]) begin
              state_r <= ST_LOCKED;
              owner_r <= win_s;
            end else begin
              state_r <= ST_ARB;
            end
          end else begin
            state_r <= ST_ARB;
          end
`else
          if (hs_s) begin
            we_r   <= 1'b1;
            addr_r <= win_addr_s;
            data_r <= win_data_s;
            ptr_r  <= wrap_inc(win_s);
            if (bus.lock[win_s]) begin
              state_r <= ST_LOCKED;
              owner_r <= win_s;
            end else begin
              state_r <= ST_ARB;
            end
          end else begin
            state_r <= ST_ARB;
          end
`endif
        end
        ST_LOCKED: begin
          // Pointer stays frozen; ownership ends on an unlocked write or a dropped req.
          if (hs_s) begin
            we_r   <= 1'b1;
            addr_r <= win_addr_s;
            data_r <= win_data_s;
            if (bus.lock[owner_r]) begin
              state_r <= ST_LOCKED;
            end else begin
              state_r <= ST_ARB;
            end
          end else begin
            state_r <= ST_ARB;
          end
        end
        default: begin
          state_r <= RESET_STATE;
        end
      endcase
    end
  end

`ifdef BOARD_CLEAR_EN
  assign busy = (state_r == ST_CLEAR);
`else
  logic clear_unused_s;
  assign clear_unused_s = clear_i;
  assign busy           = 1'b0;
`endif

  assign we_ram_board         = we_r;
  assign addr_ram_board       = addr_r;
  assign bus_data_o_ram_board = data_r;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Scoreboard bench for board_ram_arbiter: a cycle-level reference model
// predicts grants/busy and queues expected RAM writes with their due cycle;
// a negedge monitor pops and compares every write the DUT presents.
module tb_board_ram_arbiter;
  localparam int N  = 3;
  localparam int AW = 5 * N;
  localparam int DW = 10 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_i = 1'b0;
  logic we_ram_board;
  logic [4:0] addr_ram_board;
  logic [9:0] bus_data_o_ram_board;
  logic busy;

  board_ram_arbiter_if #(.NUM_REQ(N)) bus_if ();

  board_ram_arbiter #(.NUM_REQ(N)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus_if),
    .clear_i              (clear_i),
    .we_ram_board         (we_ram_board),
    .addr_ram_board       (addr_ram_board),
    .bus_data_o_ram_board (bus_data_o_ram_board),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] a;
    logic [9:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model state
  int  m_ptr = 0;
  int  m_owner = -1;
  int  m_clr_left = 0;
  bit  chk_zero = 1'b0;

`ifdef BOARD_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  // Monitor: every DUT write must match the oldest expected write, in the due cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_write cyc=%0d: no write seen, expected addr=%0d data=0x%0h due cyc=%0d",
               cyc, exp_q[0].a, exp_q[0].d, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (we_ram_board === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write cyc=%0d: got addr=%0d data=0x%0h, expected no write",
                 cyc, addr_ram_board, bus_data_o_ram_board);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || addr_ram_board !== e.a || bus_data_o_ram_board !== e.d) begin
          errors++;
          $display("FAIL ram_write cyc=%0d: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h at cyc=%0d",
                   cyc, addr_ram_board, bus_data_o_ram_board, e.a, e.d, e.cyc);
        end
      end
    end
  end

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.cyc = cyc + 1;
    e.a   = a[4:0];
    e.d   = d[9:0];
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs, check grant/busy against the model, advance the model.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                      input logic clr, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    logic [N-1:0] eg;
    logic         eb;
    int           win;
    @(posedge clk);
    cyc++;
    #1;
    rst           = r;
    bus_if.req    = rq;
    bus_if.lock   = lk;
    bus_if.addr_i = ad;
    bus_if.data_i = dt;
    clear_i       = clr;
    #1;
    if (chk_zero) begin
      checks++;
      if (we_ram_board !== 1'b0 || addr_ram_board !== 5'd0 || bus_data_o_ram_board !== 10'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: got we=%b addr=%0d data=0x%0h, expected all 0",
                 cyc, we_ram_board, addr_ram_board, bus_data_o_ram_board);
      end
    end
    eg = '0;
    eb = 1'b0;
    if (r) begin
      m_ptr      = 0;
      m_owner    = -1;
      m_clr_left = CLR_EN ? 32 : 0;
    end else if (m_clr_left > 0) begin
      eb = 1'b1;
      push_wr(32 - m_clr_left, 0);
      m_clr_left--;
    end else if (m_owner >= 0) begin
      if (rq[m_owner]) begin
        eg[m_owner] = 1'b1;
        push_wr(int'(ad[m_owner*5 +: 5]), int'(dt[m_owner*10 +: 10]));
        if (!lk[m_owner]) m_owner = -1;
      end else begin
        m_owner = -1;
      end
    end else if (CLR_EN && clr) begin
      m_clr_left = 32;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && rq[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
        eg[win] = 1'b1;
        push_wr(int'(ad[win*5 +: 5]), int'(dt[win*10 +: 10]));
        m_ptr = (win + 1) % N;
        if (lk[win]) m_owner = win;
      end
    end
    checks++;
    if (bus_if.gnt !== eg) begin
      errors++;
      $display("FAIL gnt cyc=%0d: got %b, expected %b", cyc, bus_if.gnt, eg);
    end
    if (!r) begin
      checks++;
      if (busy !== eb) begin
        errors++;
        $display("FAIL busy cyc=%0d: got %b, expected %b", cyc, busy, eb);
      end
    end
    chk_zero = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, AW'($urandom), DW'($urandom));
  endtask

  initial begin
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
    logic [N-1:0]  rq;
    logic [N-1:0]  lk;
    bus_if.req    = '0;
    bus_if.lock   = '0;
    bus_if.addr_i = '0;
    bus_if.data_i = '0;

    step(1'b1, '0, '0, 1'b0, '0, '0);
    step(1'b1, '0, '0, 1'b0, '0, '0);
`ifdef BOARD_CLEAR_EN
    // Abort the power-up sweep at address 17, then let a full sweep complete.
    idle(17);
    step(1'b1, '0, '0, 1'b0, '0, '0);
    idle(32);
`endif
    // Single requester 2, first grantable cycle.
    ad = '0; dt = '0;
    ad[14:10] = 5'd5;
    dt[29:20] = 10'h2A1;
    step(1'b0, 3'b100, '0, 1'b0, ad, dt);

    // Round robin with all requesters active.
    ad = {5'd12, 5'd7, 5'd3};
    for (int i = 0; i < 6; i++) step(1'b0, 3'b111, '0, 1'b0, ad, DW'($urandom));

    // Move pointer to 1, then requester 1 holds the port for 4 writes.
    step(1'b0, 3'b001, '0, 1'b0, AW'($urandom), DW'($urandom));
    for (int i = 0; i < 4; i++) begin
      ad = AW'($urandom);
      ad[9:5] = 5'(8 + i);
      step(1'b0, 3'b111, (i < 3) ? 3'b010 : 3'b000, 1'b0, ad, DW'($urandom));
    end
    step(1'b0, 3'b111, '0, 1'b0, AW'($urandom), DW'($urandom));

`ifdef BOARD_CLEAR_EN
    // Runtime clear beats a pending request.
    step(1'b0, 3'b001, '0, 1'b1, AW'($urandom), DW'($urandom));
    for (int i = 0; i < 33; i++) step(1'b0, 3'b001, '0, 1'b0, AW'($urandom), DW'($urandom));
`endif

    // Randomized traffic with occasional locks, clears and resets.
    for (int i = 0; i < 1500; i++) begin
      rq = N'($urandom);
      lk = '0;
      for (int j = 0; j < N; j++) lk[j] = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 149) == 0), rq, lk, ($urandom_range(0, 24) == 0),
           AW'($urandom), DW'($urandom));
    end

    idle(40);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_ram_arbiter.md
# board_ram_arbiter

Arbitrates the single write port of the board RAM (5-bit address, 10-bit data word) among several requesters: the token generator, player-move logic and future overlays. It uses a round-robin req/gnt handshake with an optional burst lock. It also runs a clear sweep that zeroes the whole board after reset or on request. It sits between the requesters and the board RAM write port.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..8); requester index i uses slice i of each flattened bus.
- `clk`  in  1: system clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NUM_REQ: write request, one bit per requester.
- `lock`  in  NUM_REQ: hold ownership after the current grant; meaningful only while `req[i]` is also high.
- `addr_i`  in  5*NUM_REQ: board address, requester i at `[5i+4:5i]`.
- `data_i`  in  10*NUM_REQ: board data word, requester i at `[10i+9:10i]`.
- `clear_i`  in  1: single-cycle pulse that starts a board clear sweep.
- `gnt`  out  NUM_REQ: combinational one-hot grant; the handshake completes on the edge where `req[i] & gnt[i]`.
- `we_ram_board`  out  1: registered RAM write enable.
- `addr_ram_board`  out  5: registered RAM address.
- `bus_data_o_ram_board`  out  10: registered RAM write data.
- `busy`  out  1: high while a clear sweep runs.

## Operation
- States: CLEAR, ARB, LOCKED.
- Reset values:
  - `we_ram_board`=0, `addr_ram_board`=0, `bus_data_o_ram_board`=0.
  - `gnt`=0 while `rst` is high.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Sweep counter=0.
  - State=CLEAR with the macro, ARB without it.
- CLEAR:
  - `gnt`=0 and `busy`=1.
  - Each cycle registers a write of data 0 to the counter address, then increments the counter.
  - After address 31, the state goes to ARB and the counter returns to 0.
  - `clear_i` is ignored while in CLEAR.
- ARB:
  - Grants the requester with `req` high that is first at or after the pointer, wrapping modulo NUM_REQ.
  - On a completed handshake:
    - The winner's addr/data are registered with `we_ram_board`=1.
    - The pointer moves to winner+1, wrapping to 0 after NUM_REQ-1.
    - If `lock[winner]`=1, the state goes to LOCKED (owner=winner).
  - With no request, `we_ram_board`=0 next cycle; addr/data registers hold their previous values.
  - A `clear_i` pulse in ARB takes priority over requests: `gnt`=0 that cycle, and the state goes to CLEAR next cycle.
- LOCKED:
  - Only the owner can be granted; `gnt[owner]`=`req[owner]`, all other grants are 0.
  - The pointer is frozen.
  - The state returns to ARB at the edge where the owner completes a handshake with `lock[owner]`=0, or where `req[owner]`=0.
  - `clear_i` is ignored in LOCKED.
- A requester keeping `req` high after a handshake makes a new request; back-to-back writes run at one per cycle.
- `gnt` is always one-hot or zero, and a grant is never given to a requester whose `req` is low.

## Timing
- Handshake in cycle N → `we_ram_board`, `addr_ram_board` and `bus_data_o_ram_board` are valid in cycle N+1, for exactly one cycle per write.
- Clear sweep, counting the first cycle with `rst` low as cycle 0:
  - The write of address k appears in cycle k+1, for k=0..31.
  - `busy` is high in cycles 0..31.
  - The first grant is possible in cycle 32.
- Runtime clear: a `clear_i` pulse in cycle N gives `busy` high in N+1..N+32, and the address-0 write appears in N+2.
- `rst` asserted mid-sweep or mid-lock takes effect at the next edge: the counter and pointer go to 0 and the state restarts as from power-up.
- Combinational path from `req`/`lock` to `gnt` only; there is no combinational path to the RAM outputs.

## Configuration
- `BOARD_CLEAR_EN` defined:
  - The CLEAR state, sweep counter, `clear_i` handling and `busy` are compiled in, with behaviour as above.
- `BOARD_CLEAR_EN` undefined:
  - There is no CLEAR state, and reset enters ARB directly.
  - `clear_i` is ignored and `busy` is tied 0.
  - The first grant is possible in the first cycle after `rst` falls.

## Test plan
- Reset release with `BOARD_CLEAR_EN` → 32 writes, addresses 0..31 with data 0 in cycles 1..32, `busy` high cycles 0..31, `gnt`=0 throughout, first grant in cycle 32.
- NUM_REQ=3, all `req` held high, `lock`=0, addr_i = 3/7/12 → grants in order 0,1,2,0,1,2; RAM outputs show addresses 3,7,12,3,7,12 one cycle after each grant.
- Requester 1 holds `req`+`lock` for 4 handshakes (addresses 8..11), with requesters 0 and 2 requesting throughout → `gnt` stays 0b010 for those 4 cycles; after `lock` drops, the next grant goes to requester 2.
- `clear_i` pulse while requester 0 is requesting in ARB → `gnt`=0 that cycle, 32 zero writes follow, then requester 0 is granted.
- `rst` asserted at sweep address 17 → outputs go to 0 next cycle, and the sweep restarts at address 0 after release.
- Without `BOARD_CLEAR_EN`: single `req[2]` with addr 5, data 0x2A1, in the first cycle after reset → `gnt`=0b100 that cycle; next cycle `we_ram_board`=1, addr 5, data 0x2A1.
